// File: rtl/abi_step_decoder.sv
// Quadrature/index front end for the commutation path: synchronises and de-glitches
// A/B/I, decodes quadrature edges into step pulses and aligns to the index mark.
module abi_step_decoder #(
  parameter int K_NSUBSTEPS     = 10,
  parameter int K_FILTER_DEPTH  = 3,
  parameter int K_INDEX_STEP    = 0,
  parameter int K_INDEX_SUBSTEP = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_enc_a,
  input  logic                           i_enc_b,
  input  logic                           i_enc_i,
  input  logic                           i_enable,
  input  logic                           i_dir_invert,
  input  logic                           i_clear_error,
  output logic                           o_step_trigger,
  output logic                           o_step_reverse,
  output logic                           o_force_step_trigger,
  output logic [2:0]                     o_force_step_value,
  output logic [$clog2(K_NSUBSTEPS)-1:0] o_force_substep,
  output logic                           o_aligned,
  output logic                           o_error,
  output logic signed [15:0]             o_edge_count
);

  localparam int SUB_W = $clog2(K_NSUBSTEPS);
  localparam logic [3:0] CNT_LAST = 4'(K_FILTER_DEPTH - 1);

  typedef enum logic [1:0] {S_DISABLED, S_ALIGN, S_RUN} state_t;

  state_t state, state_n;

  // Bit order in the input vectors is {I, A, B}
  logic [2:0] sync_p0, sync_p1;
  logic [2:0] filt_p2;
  logic [3:0] cnt_p2 [3];
  logic [2:0] prev_p3;

  logic [1:0] pos_cur, pos_prev, delta;
  logic       edge_fwd, edge_rev, illegal, step_edge, idx_rise, dir_rev;

  logic              trig_n, rev_n, force_n, err_n;
  logic signed [15:0] count_n;

  function automatic logic signed [15:0] sat_step(input logic signed [15:0] c,
                                                  input logic down);
    if (down) return (c == 16'sh8000) ? c : c - 16'sd1;
    else      return (c == 16'sh7fff) ? c : c + 16'sd1;
  endfunction

  // ---- stage p0/p1: two-flop synchroniser; stage p2: per-input glitch filter ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      filt_p2 <= '0;
      prev_p3 <= '0;
      for (int k = 0; k < 3; k++) cnt_p2[k] <= '0;
    end else begin
      sync_p0 <= {i_enc_i, i_enc_a, i_enc_b};
      sync_p1 <= sync_p0;
      prev_p3 <= filt_p2;
      for (int k = 0; k < 3; k++) begin
        if (sync_p1[k] == filt_p2[k]) begin
          cnt_p2[k] <= '0;
        end else if (cnt_p2[k] == CNT_LAST) begin
          filt_p2[k] <= sync_p1[k];
          cnt_p2[k]  <= '0;
        end else begin
          cnt_p2[k] <= cnt_p2[k] + 4'd1;
        end
      end
    end
  end

  // ---- stage p3: decode; Gray position {A, A^B} steps +1 going forward ----
  always_comb begin
    pos_cur   = {filt_p2[1], filt_p2[1] ^ filt_p2[0]};
    pos_prev  = {prev_p3[1], prev_p3[1] ^ prev_p3[0]};
    delta     = pos_cur - pos_prev;
    edge_fwd  = (delta == 2'd1);
    edge_rev  = (delta == 2'd3);
    illegal   = (delta == 2'd2);
    step_edge = edge_fwd | edge_rev;
    idx_rise  = filt_p2[2] & ~prev_p3[2];
    dir_rev   = edge_rev ^ i_dir_invert;
  end

  always_comb begin
    state_n = state;
    trig_n  = 1'b0;
    force_n = 1'b0;
    rev_n   = o_step_reverse;
    count_n = o_edge_count;
    err_n   = i_clear_error ? 1'b0 : o_error;
    if (!i_enable) begin
      state_n = S_DISABLED;
    end else begin
      case (state)
        S_DISABLED: state_n = S_ALIGN;
        S_ALIGN, S_RUN: begin
          if (illegal) err_n = 1'b1;
          if (step_edge) begin
            count_n = sat_step(o_edge_count, dir_rev);
            if (state == S_RUN) begin
              trig_n = 1'b1;
              rev_n  = dir_rev;
            end
          end
          // Index wins over a simultaneous count update
          if (idx_rise) begin
            force_n = 1'b1;
            count_n = '0;
            state_n = S_RUN;
          end
        end
        default: state_n = S_DISABLED;
      endcase
    end
  end

  // ---- stage p4: registered outputs ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                <= S_DISABLED;
      o_step_trigger       <= 1'b0;
      o_step_reverse       <= 1'b0;
      o_force_step_trigger <= 1'b0;
      o_error              <= 1'b0;
      o_edge_count         <= '0;
    end else begin
      state                <= state_n;
      o_step_trigger       <= trig_n;
      o_step_reverse       <= rev_n;
      o_force_step_trigger <= force_n;
      o_error              <= err_n;
      o_edge_count         <= count_n;
    end
  end

  assign o_aligned          = (state == S_RUN);
  assign o_force_step_value = 3'(K_INDEX_STEP);
  assign o_force_substep    = SUB_W'(K_INDEX_SUBSTEP);

endmodule

// File: tb/tb_abi_step_decoder.sv
// Scenario bench for abi_step_decoder: step/index pulses are predicted into queues
// at drive time and matched (cycle, direction, values) when the DUT emits them.
module tb_abi_step_decoder;

  localparam int LAT = 6;

  logic clk = 1'b0;
  logic rst, enc_a, enc_b, enc_i, enable, dir_invert, clear_error;
  logic step_trigger, step_reverse, force_step_trigger, aligned, error;
  logic [2:0] force_step_value;
  logic [3:0] force_substep;
  logic signed [15:0] edge_count;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int   at;
    logic rev;
  } step_exp_t;

  step_exp_t step_q[$];
  int        force_q[$];
  step_exp_t se;
  int        fe;

  abi_step_decoder #(
    .K_NSUBSTEPS(10), .K_FILTER_DEPTH(3), .K_INDEX_STEP(0), .K_INDEX_SUBSTEP(0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enc_a(enc_a), .i_enc_b(enc_b), .i_enc_i(enc_i),
    .i_enable(enable), .i_dir_invert(dir_invert), .i_clear_error(clear_error),
    .o_step_trigger(step_trigger), .o_step_reverse(step_reverse),
    .o_force_step_trigger(force_step_trigger), .o_force_step_value(force_step_value),
    .o_force_substep(force_substep), .o_aligned(aligned), .o_error(error),
    .o_edge_count(edge_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pulse must match the oldest outstanding prediction
  always @(negedge clk) begin
    if (step_trigger === 1'b1) begin
      checks++;
      if (step_q.size() == 0) begin
        errors++;
        $display("FAIL step_unexpected cyc=%0d rev=%0b required no pulse", cyc, step_reverse);
      end else begin
        se = step_q.pop_front();
        if (cyc != se.at || step_reverse !== se.rev) begin
          errors++;
          $display("FAIL step_event got cyc=%0d rev=%0b required cyc=%0d rev=%0b",
                   cyc, step_reverse, se.at, se.rev);
        end
      end
    end
    if (force_step_trigger === 1'b1) begin
      checks++;
      if (force_q.size() == 0) begin
        errors++;
        $display("FAIL force_unexpected cyc=%0d required no pulse", cyc);
      end else begin
        fe = force_q.pop_front();
        if (cyc != fe || force_step_value !== 3'd0 || force_substep !== 4'd0) begin
          errors++;
          $display("FAIL force_event got cyc=%0d val=%0d sub=%0d required cyc=%0d val=0 sub=0",
                   cyc, force_step_value, force_substep, fe);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_ab(input logic a, input logic b, input logic expect_step,
                          input logic rev);
    step_exp_t e;
    enc_a = a;
    enc_b = b;
    if (expect_step) begin
      e.at  = cyc + LAT;
      e.rev = rev;
      step_q.push_back(e);
    end
    tick(8);
  endtask

  task automatic pulse_index();
    enc_i = 1'b1;
    force_q.push_back(cyc + LAT);
    tick(10);
    enc_i = 1'b0;
    tick(5);
  endtask

  task automatic test_reset();
    rst = 1'b1; enc_a = 0; enc_b = 0; enc_i = 0;
    enable = 0; dir_invert = 0; clear_error = 0;
    tick(2);
    checks++;
    if ({step_trigger, step_reverse, force_step_trigger, aligned, error} !== 5'b0 ||
        edge_count !== 16'sd0 || force_step_value !== 3'd0 || force_substep !== 4'd0) begin
      errors++;
      $display("FAIL reset_state got trig=%b rev=%b frc=%b al=%b err=%b cnt=%0d val=%0d sub=%0d required all 0",
               step_trigger, step_reverse, force_step_trigger, aligned, error, edge_count,
               force_step_value, force_substep);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_align_count();
    enable = 1'b1;
    tick(3);
    drive_ab(0, 1, 0, 0);
    drive_ab(1, 1, 0, 0);
    drive_ab(1, 0, 0, 0);
    drive_ab(0, 0, 0, 0);
    tick(2);
    checks++;
    if (edge_count !== 16'sd4 || aligned !== 1'b0) begin
      errors++;
      $display("FAIL align_count got cnt=%0d al=%b required cnt=4 al=0", edge_count, aligned);
    end
  endtask

  task automatic test_index_run();
    pulse_index();
    checks++;
    if (aligned !== 1'b1 || edge_count !== 16'sd0) begin
      errors++;
      $display("FAIL index_align got al=%b cnt=%0d required al=1 cnt=0", aligned, edge_count);
    end
    drive_ab(0, 1, 1, 0);
    drive_ab(1, 1, 1, 0);
    drive_ab(1, 0, 1, 0);
    checks++;
    if (edge_count !== 16'sd3 || step_reverse !== 1'b0) begin
      errors++;
      $display("FAIL run_forward got cnt=%0d rev=%b required cnt=3 rev=0", edge_count, step_reverse);
    end
  endtask

  task automatic test_direction();
    drive_ab(1, 1, 1, 1);
    drive_ab(0, 1, 1, 1);
    drive_ab(0, 0, 1, 1);
    checks++;
    if (edge_count !== 16'sd0 || step_reverse !== 1'b1) begin
      errors++;
      $display("FAIL reverse got cnt=%0d rev=%b required cnt=0 rev=1", edge_count, step_reverse);
    end
    dir_invert = 1'b1;
    drive_ab(1, 0, 1, 0);
    drive_ab(1, 1, 1, 0);
    checks++;
    if (edge_count !== 16'sd2 || step_reverse !== 1'b0) begin
      errors++;
      $display("FAIL inverted got cnt=%0d rev=%b required cnt=2 rev=0", edge_count, step_reverse);
    end
    dir_invert = 1'b0;
  endtask

  task automatic test_glitch();
    step_exp_t e;
    enc_a = 1'b0;
    tick(2);
    enc_a = 1'b1;
    tick(10);
    checks++;
    if (edge_count !== 16'sd2) begin
      errors++;
      $display("FAIL glitch_reject got cnt=%0d required 2", edge_count);
    end
    enc_a = 1'b0;
    e.at = cyc + LAT; e.rev = 1'b1; step_q.push_back(e);
    tick(3);
    enc_a = 1'b1;
    e.at = cyc + LAT; e.rev = 1'b0; step_q.push_back(e);
    tick(10);
    checks++;
    if (edge_count !== 16'sd2 || step_q.size() != 0) begin
      errors++;
      $display("FAIL glitch_accept got cnt=%0d pending=%0d required cnt=2 pending=0",
               edge_count, step_q.size());
    end
  endtask

  task automatic test_error();
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL error_clean got %b required 0", error);
    end
    drive_ab(0, 0, 0, 0);
    tick(2);
    checks++;
    if (error !== 1'b1 || edge_count !== 16'sd2) begin
      errors++;
      $display("FAIL error_set got err=%b cnt=%0d required err=1 cnt=2", error, edge_count);
    end
    enc_a = 1'b1; enc_b = 1'b1;
    tick(LAT - 1);
    clear_error = 1'b1;
    tick(1);
    clear_error = 1'b0;
    tick(5);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL error_set_wins got %b required 1", error);
    end
    clear_error = 1'b1;
    tick(1);
    clear_error = 1'b0;
    tick(1);
    checks++;
    if (error !== 1'b0 || edge_count !== 16'sd2) begin
      errors++;
      $display("FAIL error_clear got err=%b cnt=%0d required err=0 cnt=2", error, edge_count);
    end
  endtask

  task automatic test_disable_reset();
    drive_ab(1, 0, 1, 0);
    enc_a = 1'b0; enc_b = 1'b0;
    tick(LAT - 1);
    enable = 1'b0;
    tick(6);
    checks++;
    if (aligned !== 1'b0 || edge_count !== 16'sd3) begin
      errors++;
      $display("FAIL disable_hold got al=%b cnt=%0d required al=0 cnt=3", aligned, edge_count);
    end
    drive_ab(0, 1, 0, 0);
    drive_ab(0, 0, 0, 0);
    checks++;
    if (edge_count !== 16'sd3) begin
      errors++;
      $display("FAIL disabled_edges got cnt=%0d required 3", edge_count);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if ({step_trigger, step_reverse, force_step_trigger, aligned, error} !== 5'b0 ||
        edge_count !== 16'sd0) begin
      errors++;
      $display("FAIL midrun_reset got trig=%b rev=%b frc=%b al=%b err=%b cnt=%0d required all 0",
               step_trigger, step_reverse, force_step_trigger, aligned, error, edge_count);
    end
    enable = 1'b1;
    tick(3);
    drive_ab(0, 1, 0, 0);
    checks++;
    if (edge_count !== 16'sd1 || aligned !== 1'b0) begin
      errors++;
      $display("FAIL realign_wait got cnt=%0d al=%b required cnt=1 al=0", edge_count, aligned);
    end
    pulse_index();
    checks++;
    if (aligned !== 1'b1 || edge_count !== 16'sd0) begin
      errors++;
      $display("FAIL realign got al=%b cnt=%0d required al=1 cnt=0", aligned, edge_count);
    end
    drive_ab(1, 1, 1, 0);
    pulse_index();
    checks++;
    if (edge_count !== 16'sd0 || aligned !== 1'b1) begin
      errors++;
      $display("FAIL resync got cnt=%0d al=%b required cnt=0 al=1", edge_count, aligned);
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 50 && (step_q.size() != 0 || force_q.size() != 0); i++) tick(1);
    checks++;
    if (step_q.size() != 0 || force_q.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got step=%0d force=%0d outstanding required 0",
               step_q.size(), force_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_align_count();
    test_index_run();
    test_direction();
    test_glitch();
    test_error();
    test_disable_reset();
    test_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/abi_step_decoder.md
Name: abi_step_decoder

Overview:
- Front-end stage for the motor commutation path: conditions raw quadrature encoder inputs (A, B, index I) and converts them into step events for the downstream commutation pattern generator.
- Produces a one-cycle step-trigger pulse with a direction flag per valid quadrature edge, and a force-step pulse carrying step/substep values on each index pulse.
- Flags illegal quadrature transitions and keeps a signed edge count since the last index.

Parameters:
K_NSUBSTEPS, 10, substeps per commutation step; sets the width of o_force_substep ($clog2(K_NSUBSTEPS)).
K_FILTER_DEPTH, 3, consecutive stable cycles required before a synchronised input is accepted (range 1..15).
K_INDEX_STEP, 0, commutation step (0..5) emitted on index.
K_INDEX_SUBSTEP, 0, substep (0..K_NSUBSTEPS-1) emitted on index.

Ports:
i_clk  in  1  main clock
i_rst  in  1  synchronous active-high reset
i_enc_a  in  1  raw encoder A, asynchronous
i_enc_b  in  1  raw encoder B, asynchronous
i_enc_i  in  1  raw encoder index, asynchronous
i_enable  in  1  decoder enable
i_dir_invert  in  1  swap the meaning of forward/reverse
i_clear_error  in  1  clears o_error
o_step_trigger  out  1  one-cycle pulse per accepted quadrature edge
o_step_reverse  out  1  direction of the last edge; 1 = reverse
o_force_step_trigger  out  1  one-cycle pulse on index
o_force_step_value  out  3  constant K_INDEX_STEP
o_force_substep  out  $clog2(K_NSUBSTEPS)  constant K_INDEX_SUBSTEP
o_aligned  out  1  high in RUN state
o_error  out  1  sticky illegal-transition flag
o_edge_count  out  16  signed edges since last index

Behaviour:
- Clock and reset: single clock i_clk; i_rst is synchronous, active-high.
- Reset values: all outputs 0 except o_force_step_value = K_INDEX_STEP and o_force_substep = K_INDEX_SUBSTEP. Synchroniser and filter registers are 0. State is DISABLED.
- Synchronisation: each of A, B and I passes through a 2-flop synchroniser.
- Glitch filter (per input):
  - The filtered value takes the synchronised value once that value has been constant and different from the filtered value for K_FILTER_DEPTH consecutive cycles.
  - Any change restarts the count.
- Quadrature decode:
  - Compare the previous filtered {A,B} with the current filtered {A,B}.
  - Forward sequence: 00 -> 01 -> 11 -> 10 -> 00. The reverse sequence is the opposite order.
  - No change: nothing happens.
  - Both bits change in the same cycle: illegal. No trigger is issued, o_error is set, and o_edge_count is unchanged.
- Direction: dir = reverse XOR i_dir_invert.
- Latency: a raw A/B change held steady produces o_step_trigger exactly 3 + K_FILTER_DEPTH cycles later. The raw index edge to o_force_step_trigger has the same latency.
- o_step_reverse is registered together with the trigger pulse and held between pulses.
- FSM:
  - DISABLED: no pulses; o_aligned = 0; the filters keep running. i_enable = 1 -> ALIGN.
  - ALIGN: edges update o_edge_count but produce no o_step_trigger. A filtered index rising edge produces o_force_step_trigger, clears o_edge_count and moves to RUN.
  - RUN: each edge produces o_step_trigger. Each index rising edge re-issues o_force_step_trigger (resync) and clears o_edge_count.
  - i_enable = 0 in any state -> DISABLED on the next cycle. Any pulse pending in that cycle is suppressed; o_edge_count is held.
- Edge count: +1 forward, -1 reverse (after inversion). Saturates at +32767 / -32768 with no wrap.
- Index and quadrature edge in the same cycle:
  - Both pulses are asserted.
  - The count is cleared, so the index wins over the increment.
  - In ALIGN, the edge still produces no step trigger.
- Error flag:
  - o_error is cleared by i_clear_error.
  - If a set and a clear occur in the same cycle, set wins.
- Reset mid-operation: the synchroniser and filters are flushed, the FSM returns to DISABLED, and realignment via index is required.
- Filter start-up: on the first cycle after reset the filtered values equal 0, so inputs held at 1 produce their first accepted edge after the filter delay.

Test Plan:
- Reset, then enable, then drive 4 forward edges 8 cycles apart with no index -> no o_step_trigger; o_edge_count = 4; o_aligned = 0.
- Drive an index pulse 10 cycles wide, then 3 forward edges -> one o_force_step_trigger with value 0 / substep 0 at raw+6 cycles; o_aligned = 1; three o_step_trigger pulses with o_step_reverse = 0; o_edge_count = 3.
- In RUN, drive the reverse sequence 00 -> 10 -> 11, with i_dir_invert = 0 then 1 -> o_step_reverse is 1 then 0; the count decrements then increments.
- A glitch 2 cycles wide on A (K_FILTER_DEPTH = 3) -> no trigger and no count change; a 3-cycle pulse is accepted.
- Jump AB 00 -> 11 -> o_error = 1 and no trigger. i_clear_error together with a new illegal jump -> o_error stays 1. A clear on its own -> 0.
- Drop i_enable mid-stream, then assert i_rst for 1 cycle -> pulses stop the next cycle; all outputs return to reset values; the next index is required before triggers resume.
